// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and a nibble validity helper.
// Imported by bcd_digit_step and bcd_updown_cnt.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t BCD_MIN_DIGIT = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down chain: steps when cin_i is set,
// rolling 9->0 (up) or 0->9 (down) and raising cout_o on roll.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       up_dn_i,
    input  logic       cin_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    // Per-digit increment/decrement with carry/borrow out
    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            if (up_dn_i) begin
                if (digit_i >= BCD_MAX_DIGIT) begin
                    digit_o = BCD_MIN_DIGIT;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == BCD_MIN_DIGIT) begin
                    digit_o = BCD_MAX_DIGIT;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_cnt.sv
// Multi-digit BCD up/down counter with clear, checked load, tc and wrap.
// BCD_UPDOWN_CNT_SAT_EN: saturate at TOP/0 instead of wrapping.
module bcd_updown_cnt
    import bcd_pkg::*;
#(
    parameter int                   DIGITS = 4,
    parameter logic [4*DIGITS-1:0]  TOP    = 16'h9999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    q_q, q_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;
    logic [W-1:0]    step_val;
    logic [DIGITS:0] carry;
    logic            at_top;
    logic            at_lim;
    logic            ld_ok;
    logic            ld_le;

    // The least significant digit always steps; each digit's roll
    // carries or borrows into the next.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_step u_step (
            .digit_i (q_q[4*i +: 4]),
            .up_dn_i (up_dn),
            .cin_i   (carry[i]),
            .digit_o (step_val[4*i +: 4]),
            .cout_o  (carry[i+1])
        );
    end

    // A borrow out of the top digit means every digit was 0.
    assign at_top = (q_q == TOP);
    assign at_lim = up_dn ? at_top : carry[DIGITS];

    assign tc = en & ~clr & ~load & at_lim;

    // Load check: legal nibbles and nibble-wise magnitude <= TOP,
    // higher digits overriding the verdict of lower ones.
    always_comb begin
        ld_ok = 1'b1;
        ld_le = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_val[4*i +: 4])) begin
                ld_ok = 1'b0;
            end
            if (load_val[4*i +: 4] > TOP[4*i +: 4]) begin
                ld_le = 1'b0;
            end else if (load_val[4*i +: 4] < TOP[4*i +: 4]) begin
                ld_le = 1'b1;
            end
        end
    end

    // Next state in priority order clr > load > en
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            if (ld_ok && ld_le) begin
                q_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            if (at_lim) begin
`ifdef BCD_UPDOWN_CNT_SAT_EN
                q_d = q_q;
`else
                q_d    = up_dn ? '0 : TOP;
                wrap_d = 1'b1;
`endif
            end else begin
                q_d = step_val;
            end
        end
    end

    // Count and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q        = q_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule

// File: doc/bcd_updown_cnt.md
# bcd_updown_cnt

Parametrised multi-digit BCD counter, the next generation of the team's fixed up-only BCD counter. It adds:
- a configurable digit count and terminal value;
- up/down counting;
- synchronous clear and parallel load with validity checking;
- terminal-count and wrap indications.

It feeds display drivers and decimal timers, and cascades through `tc`.

## Interface
- `DIGITS`, default 4: number of BCD digits, 1..8.
- `TOP`, default `16'h9999`: highest count value, BCD-encoded, width 4*DIGITS; every nibble must be ≤ 9.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous clear to 0.
- `en` input 1: count enable for one step per cycle.
- `up_dn` input 1: direction, 1 = up, 0 = down.
- `load` input 1: synchronous parallel load request.
- `load_val` input 4*DIGITS: value to load, BCD.
- `q` output 4*DIGITS: current count, BCD, registered.
- `tc` output 1: terminal count, combinational.
- `wrap` output 1: one-cycle registered pulse, high after a wrap step.
- `load_err` output 1: one-cycle registered pulse, high after a rejected load.

## Operation
- Clock and reset: single clock `clk`. `rst_n` low asynchronously sets `q`=0, `wrap`=0, `load_err`=0.
- Per-edge priority: `clr` > `load` > `en`. With none asserted, `q` holds and both pulses return to 0.
- `clr`: `q`←0; `wrap`←0; `load_err`←0.
- `load`, valid value: `load_val` is valid when every nibble is ≤ 9 and the value is ≤ `TOP`, with nibble-wise BCD magnitude compare. Result: `q`←`load_val`, `load_err`←0.
- `load`, invalid value: `q` holds; `load_err`←1 for one cycle. Load always overrides `en` that cycle.
- Up step (`en` and `up_dn`=1):
  - `q`<`TOP`: `q`←`q`+1 in BCD. Digit i rolls 9→0 and carries into digit i+1.
  - `q`==`TOP`: `q`←0, `wrap`←1.
- Down step (`en` and `up_dn`=0):
  - `q`>0: `q`←`q`−1 in BCD. Digit i rolls 0→9 and borrows from digit i+1.
  - `q`==0: `q`←`TOP`, `wrap`←1.
- `tc` = `en` & !`clr` & !`load` & ((`up_dn` & `q`==`TOP`) | (!`up_dn` & `q`==0)). It is high exactly in the cycle whose edge will wrap.
- No illegal nibble ever appears on `q`. Arithmetic is per-digit 4-bit. There is no binary add-then-correct on the full word.
- A direction change takes effect on the next edge, with no dead cycle.

## Timing
- `q` latency: 1 cycle from the edge sampling `clr`, `load` or `en`.
- `wrap` and `load_err`: asserted on the same edge that updates or rejects `q`, held for exactly one cycle unless the condition repeats.
- `tc`: combinational from `q`, `en`, `up_dn`, `clr` and `load`. It has no register, so it is usable as `en` of the next cascaded stage in the same cycle.
- Reset asserted mid-count: outputs go to reset values immediately. After deassertion, counting resumes on the first edge with `en`=1.
- The critical path is the DIGITS-long carry/borrow chain. For DIGITS=8 it must close at the target clock without pipelining.

## Configuration
- `BCD_UPDOWN_CNT_SAT_EN` defined: saturating mode.
  - Up at `TOP` holds `TOP`; down at 0 holds 0.
  - `wrap` is never asserted.
  - `tc` keeps the same definition and indicates saturation.
- Undefined: wrap-around behaviour as given in Operation.

## Structure
- Package `bcd_pkg` holds:
  - `typedef logic [3:0] bcd_digit_t`;
  - constants `BCD_MAX_DIGIT`=4'd9 and `BCD_MIN_DIGIT`=4'd0;
  - function `bcd_valid(bcd_digit_t)`.
- Sub-module `bcd_digit_step`:
  - inputs: digit, `up_dn`, `cin` (carry or borrow in);
  - outputs: next digit, `cout`.
  - The top level instantiates DIGITS copies in a generate chain and adds the `TOP` compare, load check and output registers.

## Test plan
- Reset and up count: DIGITS=2, `TOP`=8'h59, `en`=1, `up_dn`=1 from 0 for 60 cycles. `q` runs 00..59 with BCD rollover 09→10. `tc`=1 only at 59. `q`→00 with `wrap`=1 for one cycle.
- Down wrap: DIGITS=2, `TOP`=8'h59, `q`=00, `up_dn`=0, `en`=1. Next `q`=59, `wrap`=1. Then 58, and across a digit boundary 50→49.
- Load validity: `TOP`=8'h59.
  - `load_val`=8'h37: `q`=37, `load_err`=0.
  - `load_val`=8'h3A: `q` holds, `load_err`=1.
  - `load_val`=8'h60: `q` holds, `load_err`=1.
- Priority: `clr`, `load`(8'h12) and `en` together → `q`=00. Then `load`(8'h12) with `en` → `q`=12, with no increment that cycle.
- Async reset: assert `rst_n`=0 mid-cycle with `q`=8'h47. `q`=00 before the next edge, and `wrap`/`load_err` are 0.
- `BCD_UPDOWN_CNT_SAT_EN` defined: up at 59 holds 59 with `wrap`=0 and `tc`=1. Down at 00 holds 00.
